// File: rtl/rtype_instr_loader_pkg.sv
// Shared R-type constants: operation selects, function codes, field positions and a word packer.
// Used by both the instruction loader and the control unit's R-type decode.
package rtype_instr_loader_pkg;

    typedef enum logic [4:0] {
        SEL_ADD  = 5'd0,  SEL_ADDU = 5'd1,  SEL_SUB  = 5'd2,  SEL_SUBU = 5'd3,
        SEL_AND  = 5'd4,  SEL_OR   = 5'd5,  SEL_XOR  = 5'd6,  SEL_NOR  = 5'd7,
        SEL_SLT  = 5'd8,  SEL_SLTU = 5'd9,  SEL_SLL  = 5'd10, SEL_SRL  = 5'd11,
        SEL_SRA  = 5'd12, SEL_SLLV = 5'd13, SEL_SRLV = 5'd14, SEL_SRAV = 5'd15,
        SEL_JR   = 5'd16
    } rtype_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ENC  = 2'd1,
        ST_WR   = 2'd2,
        ST_FULL = 2'd3
    } loader_state_e;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;

    localparam logic [5:0] FUNC_ADD  = 6'h20;
    localparam logic [5:0] FUNC_ADDU = 6'h21;
    localparam logic [5:0] FUNC_SUB  = 6'h22;
    localparam logic [5:0] FUNC_SUBU = 6'h23;
    localparam logic [5:0] FUNC_AND  = 6'h24;
    localparam logic [5:0] FUNC_OR   = 6'h25;
    localparam logic [5:0] FUNC_XOR  = 6'h26;
    localparam logic [5:0] FUNC_NOR  = 6'h27;
    localparam logic [5:0] FUNC_SLT  = 6'h2A;
    localparam logic [5:0] FUNC_SLTU = 6'h2B;
    localparam logic [5:0] FUNC_SLL  = 6'h00;
    localparam logic [5:0] FUNC_SRL  = 6'h02;
    localparam logic [5:0] FUNC_SRA  = 6'h03;
    localparam logic [5:0] FUNC_SLLV = 6'h04;
    localparam logic [5:0] FUNC_SRLV = 6'h06;
    localparam logic [5:0] FUNC_SRAV = 6'h07;
    localparam logic [5:0] FUNC_JR   = 6'h08;

    localparam int OP_LSB    = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_LSB = 6;
    localparam int FUNC_LSB  = 0;

    function automatic logic [31:0] pack_rtype(input logic [4:0] rs, input logic [4:0] rt,
                                               input logic [4:0] rd, input logic [4:0] shamt,
                                               input logic [5:0] func);
        logic [31:0] w;
        w = 32'h0000_0000;
        w[OP_LSB +: 6]    = OP_RTYPE;
        w[RS_LSB +: 5]    = rs;
        w[RT_LSB +: 5]    = rt;
        w[RD_LSB +: 5]    = rd;
        w[SHAMT_LSB +: 5] = shamt;
        w[FUNC_LSB +: 6]  = func;
        return w;
    endfunction

endpackage

// File: rtl/rtype_instr_loader_encode.sv
// rtype_encode: combinational R-type encoder. Unused fields are masked to zero in the word
// and reported separately through strict_violation.
module rtype_encode
    import rtype_instr_loader_pkg::*;
(
    input  logic [4:0]  sel,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    output logic [31:0] word,
    output logic        legal,
    output logic        strict_violation
);

    logic [5:0] func_s;
    logic       use_rs_s;
    logic       use_rt_s;
    logic       use_rd_s;
    logic       use_shamt_s;

    // Select function code and which fields the operation actually consumes.
    always_comb begin
        func_s      = FUNC_SLL;
        legal       = 1'b1;
        use_rs_s    = 1'b1;
        use_rt_s    = 1'b1;
        use_rd_s    = 1'b1;
        use_shamt_s = 1'b0;
        case (sel)
            SEL_ADD:  func_s = FUNC_ADD;
            SEL_ADDU: func_s = FUNC_ADDU;
            SEL_SUB:  func_s = FUNC_SUB;
            SEL_SUBU: func_s = FUNC_SUBU;
            SEL_AND:  func_s = FUNC_AND;
            SEL_OR:   func_s = FUNC_OR;
            SEL_XOR:  func_s = FUNC_XOR;
            SEL_NOR:  func_s = FUNC_NOR;
            SEL_SLT:  func_s = FUNC_SLT;
            SEL_SLTU: func_s = FUNC_SLTU;
            SEL_SLL:  begin func_s = FUNC_SLL; use_rs_s = 1'b0; use_shamt_s = 1'b1; end
            SEL_SRL:  begin func_s = FUNC_SRL; use_rs_s = 1'b0; use_shamt_s = 1'b1; end
            SEL_SRA:  begin func_s = FUNC_SRA; use_rs_s = 1'b0; use_shamt_s = 1'b1; end
            SEL_SLLV: func_s = FUNC_SLLV;
            SEL_SRLV: func_s = FUNC_SRLV;
            SEL_SRAV: func_s = FUNC_SRAV;
            SEL_JR:   begin func_s = FUNC_JR; use_rt_s = 1'b0; use_rd_s = 1'b0; end
            default:  legal = 1'b0;
        endcase
    end

    assign word = pack_rtype(use_rs_s    ? rs    : 5'd0,
                             use_rt_s    ? rt    : 5'd0,
                             use_rd_s    ? rd    : 5'd0,
                             use_shamt_s ? shamt : 5'd0,
                             func_s);

    assign strict_violation = (!use_rs_s    && (rs    != 5'd0)) ||
                              (!use_rt_s    && (rt    != 5'd0)) ||
                              (!use_rd_s    && (rd    != 5'd0)) ||
                              (!use_shamt_s && (shamt != 5'd0));

endmodule

// File: rtl/rtype_instr_loader.sv
// Sequential R-type encoder/loader writing consecutive instruction-memory words.
// Optional LOADER_STRICT_EN: nonzero unused fields reject the operation instead of being masked.
module rtype_instr_loader
    import rtype_instr_loader_pkg::*;
#(
    parameter int AW   = 6,
    parameter int BASE = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_sel,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_shamt,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          err
);

`ifdef LOADER_STRICT_EN
    localparam bit STRICT_EN = 1'b1;
`else
    localparam bit STRICT_EN = 1'b0;
`endif

    localparam logic [AW:0] LAST_COUNT = (AW+1)'((1 << AW) - 1);

    loader_state_e state_r;
    logic [4:0]    sel_r, rs_r, rt_r, rd_r, shamt_r;
    logic [31:0]   word_r;
    logic [AW-1:0] ptr_r;
    logic [AW:0]   count_r;
    logic          in_ready_r, imem_we_r, full_r, err_r;
    logic [AW-1:0] imem_addr_r;
    logic [31:0]   imem_wdata_r;

    logic [31:0]   word_s;
    logic          legal_s;
    logic          strict_s;
    logic          reject_s;

    rtype_encode u_encode (
        .sel              (sel_r),
        .rs               (rs_r),
        .rt               (rt_r),
        .rd               (rd_r),
        .shamt            (shamt_r),
        .word             (word_s),
        .legal            (legal_s),
        .strict_violation (strict_s)
    );

    assign reject_s = !legal_s || (STRICT_EN && strict_s);

    // Loader FSM; the write strobe is registered, so it is high the cycle after WR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            sel_r        <= 5'd0;
            rs_r         <= 5'd0;
            rt_r         <= 5'd0;
            rd_r         <= 5'd0;
            shamt_r      <= 5'd0;
            word_r       <= 32'h0000_0000;
            ptr_r        <= AW'(BASE);
            count_r      <= '0;
            in_ready_r   <= 1'b1;
            imem_we_r    <= 1'b0;
            imem_addr_r  <= AW'(BASE);
            imem_wdata_r <= 32'h0000_0000;
            full_r       <= 1'b0;
            err_r        <= 1'b0;
        end else if (clr) begin
            state_r      <= ST_IDLE;
            word_r       <= 32'h0000_0000;
            ptr_r        <= AW'(BASE);
            count_r      <= '0;
            in_ready_r   <= 1'b1;
            imem_we_r    <= 1'b0;
            imem_addr_r  <= AW'(BASE);
            imem_wdata_r <= 32'h0000_0000;
            full_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            imem_we_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        sel_r      <= in_sel;
                        rs_r       <= in_rs;
                        rt_r       <= in_rt;
                        rd_r       <= in_rd;
                        shamt_r    <= in_shamt;
                        in_ready_r <= 1'b0;
                        state_r    <= ST_ENC;
                    end
                end
                ST_ENC: begin
                    if (reject_s) begin
                        err_r      <= 1'b1;
                        in_ready_r <= 1'b1;
                        state_r    <= ST_IDLE;
                    end else begin
                        word_r  <= word_s;
                        state_r <= ST_WR;
                    end
                end
                ST_WR: begin
                    imem_we_r    <= 1'b1;
                    imem_addr_r  <= ptr_r;
                    imem_wdata_r <= word_r;
                    ptr_r        <= ptr_r + AW'(1);
                    count_r      <= count_r + (AW+1)'(1);
                    if (count_r == LAST_COUNT) begin
                        full_r  <= 1'b1;
                        state_r <= ST_FULL;
                    end else begin
                        in_ready_r <= 1'b1;
                        state_r    <= ST_IDLE;
                    end
                end
                ST_FULL: state_r <= ST_FULL;
                default: begin
                    in_ready_r <= 1'b1;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign imem_we    = imem_we_r;
    assign imem_addr  = imem_addr_r;
    assign imem_wdata = imem_wdata_r;
    assign count      = count_r;
    assign full       = full_r;
    assign err        = err_r;

endmodule

// File: tb/tb_rtype_instr_loader.sv
// Self-checking bench for rtype_instr_loader: event-level reference model plus directed and random stimulus.
module tb_rtype_instr_loader;

    localparam int AW   = 2;
    localparam int BASE = 0;
    localparam int CAP  = 1 << AW;

`ifdef LOADER_STRICT_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic [4:0]    in_sel = 5'd0, in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0, in_shamt = 5'd0;
    logic          in_ready, imem_we, full, err;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rtype_instr_loader #(.AW(AW), .BASE(BASE)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .full(full), .err(err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference encoding straight from the field table.
    function automatic logic [31:0] model_word(input int sel, input int rs, input int rt,
                                               input int rd, input int sh);
        int funcs [0:16];
        bit shift_op, jr_op;
        funcs = '{32'h20, 32'h21, 32'h22, 32'h23, 32'h24, 32'h25, 32'h26, 32'h27,
                  32'h2A, 32'h2B, 32'h00, 32'h02, 32'h03, 32'h04, 32'h06, 32'h07, 32'h08};
        shift_op = (sel >= 10) && (sel <= 12);
        jr_op    = (sel == 16);
        if (sel > 16) return 32'h0;
        return 32'((shift_op ? 0 : rs) * 2097152 + (jr_op ? 0 : rt) * 65536 +
                   (jr_op ? 0 : rd) * 2048 + (shift_op ? sh : 0) * 64 + funcs[sel]);
    endfunction

    function automatic bit model_violation(input int sel, input int rs, input int rt,
                                           input int rd, input int sh);
        bit shift_op, jr_op;
        shift_op = (sel >= 10) && (sel <= 12);
        jr_op    = (sel == 16);
        return (shift_op && rs != 0) || (!shift_op && sh != 0) || (jr_op && (rt != 0 || rd != 0));
    endfunction

    // Model state: one outstanding operation, resolved 1 edge (reject) or 2 edges (write) after accept.
    int            edge_n = 0;
    bit            op_v = 1'b0, op_rej = 1'b0;
    int            op_edge = 0;
    logic [31:0]   op_word = 32'h0;
    int            m_count = 0;
    bit            m_err = 1'b0, m_full = 1'b0;
    bit            e_ready = 1'b1, e_we = 1'b0, prev_ready = 1'b1;
    logic [AW-1:0] e_addr = AW'(BASE);
    logic [31:0]   e_wdata = 32'h0;

    always @(posedge clk) begin
        edge_n++;
        if (rst || clr) begin
            op_v = 1'b0; m_count = 0; m_err = 1'b0; m_full = 1'b0;
            e_ready = 1'b1; e_we = 1'b0; e_addr = AW'(BASE); e_wdata = 32'h0;
        end else begin
            prev_ready = e_ready;
            e_we = 1'b0;
            if (op_v && op_rej && edge_n == op_edge + 1) begin
                m_err = 1'b1;
                op_v  = 1'b0;
            end
            if (op_v && !op_rej && edge_n == op_edge + 2) begin
                e_we    = 1'b1;
                e_addr  = AW'((BASE + m_count) % CAP);
                e_wdata = op_word;
                m_count++;
                if (m_count == CAP) m_full = 1'b1;
                op_v = 1'b0;
            end
            if (prev_ready && in_valid) begin
                op_v    = 1'b1;
                op_edge = edge_n;
                op_word = model_word(int'(in_sel), int'(in_rs), int'(in_rt), int'(in_rd), int'(in_shamt));
                op_rej  = (in_sel > 5'd16) ||
                          (STRICT && model_violation(int'(in_sel), int'(in_rs), int'(in_rt),
                                                     int'(in_rd), int'(in_shamt)));
            end
            e_ready = !op_v && !m_full;
        end
    end

    // Compare every cycle out of reset, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", 32'(in_ready), 32'(e_ready));
            chk("imem_we",  32'(imem_we),  32'(e_we));
            chk("count",    32'(count),    32'(m_count));
            chk("full",     32'(full),     32'(m_full));
            chk("err",      32'(err),      32'(m_err));
            if (e_we) begin
                chk("imem_addr",  32'(imem_addr), 32'(e_addr));
                chk("imem_wdata", imem_wdata,     e_wdata);
            end
        end
    end

    task automatic send(input int sel, input int rs, input int rt, input int rd, input int sh);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 16 && !ok; k++) begin
            @(negedge clk); #1;
            if (in_ready) begin
                in_valid = 1'b1;
                in_sel = 5'(sel); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd); in_shamt = 5'(sh);
                ok = 1'b1;
            end
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL send_timeout: in_ready stayed 0 for 16 cycles, expected 1");
        end
        @(negedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_write(input string nm, input logic [31:0] w, input int a);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk); #2;
            if (imem_we) seen = 1'b1;
        end
        if (!seen) begin
            tests++; fails++;
            $display("FAIL %s: imem_we never rose in 8 cycles, expected a write", nm);
        end else begin
            chk({nm, "_data"}, imem_wdata, w);
            chk({nm, "_addr"}, 32'(imem_addr), 32'(a));
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk); #1 clr = 1'b1;
        @(negedge clk); #1 clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        chk("pin_add", model_word(0, 1, 2, 3, 0),  32'h0022_1820);
        chk("pin_sll", model_word(10, 0, 5, 4, 7), 32'h0005_21C0);
        chk("pin_jr",  model_word(16, 31, 0, 0, 0), 32'h03E0_0008);

        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_we",       32'(imem_we),  32'd0);
        chk("rst_addr",     32'(imem_addr), 32'(BASE));
        chk("rst_wdata",    imem_wdata,    32'h0);
        chk("rst_count",    32'(count),    32'd0);
        chk("rst_full",     32'(full),     32'd0);
        chk("rst_err",      32'(err),      32'd0);

        send(0, 1, 2, 3, 0);
        expect_write("add", 32'h0022_1820, 0);
        chk("add_count", 32'(count), 32'd1);

        pulse_clr();
        send(10, 0, 5, 4, 7);
        expect_write("sll", 32'h0005_21C0, 0);
        send(16, 31, 0, 0, 0);
        expect_write("jr", 32'h03E0_0008, 1);
        send(1, 4, 5, 6, 0);
        send(2, 7, 8, 9, 0);
        idle(4);
        chk("full_flag",  32'(full),     32'd1);
        chk("full_ready", 32'(in_ready), 32'd0);
        @(negedge clk); #1;
        in_valid = 1'b1; in_sel = 5'd0; in_rs = 5'd1; in_rt = 5'd1; in_rd = 5'd1; in_shamt = 5'd0;
        idle(6);
        in_valid = 1'b0;
        chk("full_count_held", 32'(count), 32'd4);
        pulse_clr();
        #1;
        chk("clr_count", 32'(count),     32'd0);
        chk("clr_addr",  32'(imem_addr), 32'(BASE));

        send(20, 1, 2, 3, 0);
        idle(3);
        chk("illegal_err", 32'(err), 32'd1);
        send(0, 1, 2, 3, 0);
        expect_write("after_illegal", 32'h0022_1820, 0);

        pulse_clr();
        send(0, 1, 2, 3, 3);
        if (STRICT) begin
            idle(4);
            chk("strict_err",   32'(err),   32'd1);
            chk("strict_count", 32'(count), 32'd0);
        end else begin
            expect_write("masked_shamt", 32'h0022_1820, 0);
        end

        for (int c = 0; c < 800; c++) begin
            @(negedge clk); #1;
            clr      = ($urandom_range(0, 39) == 0);
            in_valid = ($urandom_range(0, 2) != 0);
            in_sel   = 5'($urandom_range(0, 19));
            in_rs    = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
            in_rt    = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
            in_rd    = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
            in_shamt = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom);
        end
        @(negedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;

        pulse_clr();
        send(0, 1, 2, 3, 0);
        expect_write("pre_rst", 32'h0022_1820, 0);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_we",    32'(imem_we),   32'd0);
        chk("async_rst_ready", 32'(in_ready),  32'd1);
        chk("async_rst_count", 32'(count),     32'd0);
        chk("async_rst_addr",  32'(imem_addr), 32'(BASE));
        chk("async_rst_wdata", imem_wdata,     32'h0);
        chk("async_rst_full",  32'(full),      32'd0);
        chk("async_rst_err",   32'(err),       32'd0);
        @(negedge clk); #1 rst = 1'b0;
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rtype_instr_loader.md
# rtype_instr_loader

Sequential R-type instruction encoder and loader. Accepts symbolic R-type operations (operation select plus register/shift fields) over a valid/ready handshake, encodes each into a 32-bit MIPS word, and writes it to consecutive instruction-memory addresses. It is the encode/write counterpart of the control unit's R-type decode, and it preloads instruction memory for bring-up and self-test of the `pc_if_id_rtype` datapath.

## Interface
Parameters:
- `AW`, 6: instruction-memory word-address width; capacity is 2^AW words.
- `BASE`, 0: first word address written after reset or `clr`.

Ports:
- `clk`  in  1  single clock; all state is on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `clr`  in  1  synchronous flush: pointer to `BASE`, `count`=0, `err`=0, state IDLE.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  loader can accept an operation.
- `in_sel`  in  5  operation: 0 add, 1 addu, 2 sub, 3 subu, 4 and, 5 or, 6 xor, 7 nor, 8 slt, 9 sltu, 10 sll, 11 srl, 12 sra, 13 sllv, 14 srlv, 15 srav, 16 jr; 17–31 illegal.
- `in_rs`, `in_rt`, `in_rd`, `in_shamt`  in  5 each  instruction fields.
- `imem_we`  out  1  one-cycle write strobe.
- `imem_addr`  out  AW  write word address.
- `imem_wdata`  out  32  encoded instruction.
- `count`  out  AW+1  words written since reset/`clr`.
- `full`  out  1  all 2^AW words written.
- `err`  out  1  sticky: an operation was rejected.

## Operation
- Encoding: [31:26]=0, [25:21]=rs, [20:16]=rt, [15:11]=rd, [10:6]=shamt, [5:0]=func.
- func: add 0x20, addu 0x21, sub 0x22, subu 0x23, and 0x24, or 0x25, xor 0x26, nor 0x27, slt 0x2A, sltu 0x2B, sll 0x00, srl 0x02, sra 0x03, sllv 0x04, srlv 0x06, srav 0x07, jr 0x08.
- Unused fields: shamt for all except sll/srl/sra; rs for sll/srl/sra; rt, rd and shamt for jr.
- FSM: IDLE → ENC → WR → IDLE, or WR → FULL when the last address is written.
  - IDLE: `in_ready`=1. On `in_valid`, latch the fields and go to ENC.
  - ENC: encode into a register. For an illegal `in_sel` (or a strict violation, see Configuration), set `err` and return to IDLE with no write.
  - WR: `imem_we`=1 and `imem_addr`=ptr. Then ptr increments and `count` increments.
  - FULL: `in_ready`=0 and `full`=1. Leave only via `clr` or `rst`.
- Pointer wraps modulo 2^AW only in the arithmetic sense. FULL prevents any overwrite.
- `clr` has priority over all states, including WR: an in-flight write is aborted and `imem_we` is 0 that cycle.
- `clr` together with `in_valid` in IDLE: `clr` wins and nothing is accepted.

## Timing
- Accept at edge N. `imem_we` is high during cycle N+2 to N+3. Next accept is possible at edge N+3. Throughput is one operation per 3 cycles.
- `in_ready` is a Moore output (state only), with no combinational path from `in_valid`.
- Reset values: state IDLE, `in_ready`=1, `imem_we`=0, `imem_addr`=`BASE`, `imem_wdata`=0, `count`=0, `full`=0, `err`=0.
- `rst` asserted during WR drops `imem_we` immediately (asynchronously).

## Configuration
- `LOADER_STRICT_EN` defined: any nonzero unused field sets `err` and the operation is dropped (no write, pointer unchanged).
- `LOADER_STRICT_EN` undefined: unused fields are masked to zero and the word is written.
- An illegal `in_sel` is always rejected, with or without the macro.

## Structure
- Shared package: `in_sel` enumeration constants, the 17 func constants, `OP_RTYPE`=6'b000000, and field bit positions. The control unit uses the same constants.
- One sub-module, `rtype_encode`: combinational `sel`+fields → {word, legal, strict_violation}, registered in ENC by the parent.

## Test plan
- add: sel 0, rs 1, rt 2, rd 3 → one write at addr 0 of 0x00221820; `count`=1.
- sll: sel 10, rt 5, rd 4, shamt 7, then jr: sel 16, rs 31 → 0x000521C0 at addr 0, then 0x03E00008 at addr 1; `imem_we` exactly 2 cycles after each accept.
- Full (AW=2): 4 writes → `full`=1, `in_ready`=0. A 5th `in_valid` is never accepted. `clr` → `count`=0, addr `BASE`.
- Illegal: sel 20 → `err`=1, no `imem_we`. A following add is still written at addr 0.
- Strict: add with shamt 3 → with the macro, `err`=1 and no write. Without it, 0x00221820 is written.
- `rst` asserted mid-WR → `imem_we` falls without waiting for a clock edge; all outputs return to reset values.
